hit_tracker: RTL and testbench

Per-frame collision and hit-point tracker sitting directly downstream of the pixel-mask stage of the VGA system. It samples the heart mask and the combined ball mask at every pixel strobe, reduces them to one overlap flag per frame, and at end of frame applies damage, runs an invulnerability window, and flags death. Each HP change is reported as one byte on the UART transmitter handshake. It also drives the LED/blink status used by the display stage.

---
 rtl/hit_tracker.sv | 142 ++++++++++++++
 tb/tb_hit_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_tracker.sv
// Per-frame heart/ball collision tracker: applies damage at end of frame, runs an
// invulnerability window, latches death and reports each HP change as one UART byte.
module hit_tracker #(
    parameter int HP_MAX  = 20,
    parameter int DAMAGE  = 3,
    parameter int IFRAMES = 30,
    parameter int HP_W    = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pix_stb,
    input  logic            i_heart_px,
    input  logic            i_ball_px,
    input  logic            i_end_of_frame,
    input  logic            i_restart,
    input  logic            i_tx_idle,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_transmit,
    output logic [HP_W-1:0] o_hp,
    output logic            o_invuln,
    output logic            o_dead,
    output logic            o_hit
);

    localparam int ICNT_W = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

    localparam logic [HP_W-1:0]   HP_INIT   = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]   DMG       = HP_W'(DAMAGE);
    localparam logic [ICNT_W-1:0] ICNT_INIT = ICNT_W'(IFRAMES);
    localparam logic [7:0]        BYTE_HIT  = 8'h48;
    localparam logic [7:0]        BYTE_DEAD = 8'h44;

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                 input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    state_t            state_q, state_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              ov_q;
    logic              hit_d, fatal_d;
    logic              hit_q, invuln_q, dead_q;
    logic              pending_q;
    logic [7:0]        byte_q;
    logic [7:0]        tx_data_q;
    logic              tx_transmit_q;

    // Stage p0: qualify pixel inputs with the strobe
    logic overlap_p0, frame_p0, frame_ov_p0;
    assign overlap_p0  = i_pix_stb & i_heart_px & i_ball_px;
    assign frame_p0    = i_pix_stb & i_end_of_frame;
    assign frame_ov_p0 = ov_q | overlap_p0;

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        icnt_d  = icnt_q;
        hit_d   = 1'b0;
        fatal_d = 1'b0;
        if (frame_p0) begin
            case (state_q)
                ALIVE: begin
                    if (frame_ov_p0) begin
                        hit_d = 1'b1;
                        hp_d  = sat_sub(hp_q, DMG);
                        if (hp_d == '0) begin
                            fatal_d = 1'b1;
                            state_d = DEAD;
                        end else if (IFRAMES > 0) begin
                            state_d = INVULN;
                            icnt_d  = ICNT_INIT;
                        end
                    end
                end
                INVULN: begin
                    icnt_d = icnt_q - 1'b1;
                    if (icnt_d == '0) state_d = ALIVE;
                end
                default: ;
            endcase
        end
        // Restart overrides whatever the frame would have done
        if (i_restart) begin
            state_d = ALIVE;
            hp_d    = HP_INIT;
            icnt_d  = '0;
            hit_d   = 1'b0;
            fatal_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ALIVE;
        else       state_q <= state_d;
    end

    // Stage p1: registered game state and report queue
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hp_q          <= HP_INIT;
            icnt_q        <= '0;
            ov_q          <= 1'b0;
            hit_q         <= 1'b0;
            invuln_q      <= 1'b0;
            dead_q        <= 1'b0;
            pending_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_transmit_q <= 1'b0;
        end else begin
            hp_q     <= hp_d;
            icnt_q   <= icnt_d;
            hit_q    <= hit_d;
            invuln_q <= (state_d == INVULN);
            dead_q   <= (state_d == DEAD);
            ov_q     <= (i_restart | frame_p0) ? 1'b0 : (ov_q | overlap_p0);

            tx_transmit_q <= 1'b0;
            if (pending_q && i_tx_idle) begin
                tx_transmit_q <= 1'b1;
                tx_data_q     <= byte_q;
            end
            if (hit_d)                              pending_q <= 1'b1;
            else if (i_restart || i_tx_idle)        pending_q <= 1'b0;
        end
    end

    // Report byte is pure data, only meaningful while pending is set
    always_ff @(posedge i_clk) begin
        if (hit_d) byte_q <= fatal_d ? BYTE_DEAD : BYTE_HIT;
    end

    assign o_hp          = hp_q;
    assign o_hit         = hit_q;
    assign o_invuln      = invuln_q;
    assign o_dead        = dead_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_transmit = tx_transmit_q;

endmodule

// File: tb/tb_hit_tracker.sv
// Randomized and directed bench for hit_tracker against a frame-level game model.
module tb_hit_tracker;

    logic       clk = 1'b0;
    logic       rst, stb, heart, ball, eof, restart, idle;
    logic [7:0] tx_data;
    logic       tx_transmit;
    logic [7:0] hp;
    logic       invuln, dead, hit;

    always #5 clk = ~clk;

    hit_tracker #(.HP_MAX(20), .DAMAGE(3), .IFRAMES(30), .HP_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_heart_px(heart),
        .i_ball_px(ball), .i_end_of_frame(eof), .i_restart(restart),
        .i_tx_idle(idle), .o_tx_data(tx_data), .o_tx_transmit(tx_transmit),
        .o_hp(hp), .o_invuln(invuln), .o_dead(dead), .o_hit(hit)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: hit points, frames of invulnerability left, and one report slot
    bit   started = 0;
    int   m_hp, m_inv;
    bit   m_dead, m_ov, m_pend;
    logic [7:0] m_byte, e_txd;
    bit   e_hit, e_tx;

    always @(posedge clk) begin
        bit ovl, f, any;
        int dmg;
        if (rst) begin
            started = 1;
            m_hp = 20; m_inv = 0; m_dead = 0; m_ov = 0; m_pend = 0;
            e_hit = 0; e_tx = 0; e_txd = 8'h00;
        end else if (started) begin
            ovl = stb & heart & ball;
            f   = stb & eof;
            e_tx = 0;
            e_hit = 0;
            if (m_pend && idle) begin
                e_tx = 1; e_txd = m_byte; m_pend = 0;
            end
            if (restart) begin
                m_hp = 20; m_inv = 0; m_dead = 0; m_ov = 0; m_pend = 0;
            end else if (f) begin
                any = m_ov | ovl;
                m_ov = 0;
                if (!m_dead) begin
                    if (m_inv > 0) m_inv--;
                    else if (any) begin
                        dmg = (m_hp < 3) ? m_hp : 3;
                        m_hp -= dmg;
                        e_hit = 1;
                        m_pend = 1;
                        if (m_hp == 0) begin m_dead = 1; m_byte = 8'h44; end
                        else begin m_inv = 30; m_byte = 8'h48; end
                    end
                end
            end else begin
                m_ov |= ovl;
            end
        end
    end

    // Compare DUT to model every cycle, plus event counters for directed checks
    int tx_cnt = 0, hit_cnt = 0;
    logic [7:0] last_tx = 8'h00;

    always @(negedge clk) begin
        if (started) begin
            check("hp",       hp,          m_hp);
            check("invuln",   invuln,      (m_inv > 0) && !m_dead);
            check("dead",     dead,        m_dead);
            check("hit",      hit,         e_hit);
            check("transmit", tx_transmit, e_tx);
            check("tx_data",  tx_data,     e_txd);
        end
        if (tx_transmit === 1'b1) begin tx_cnt++; last_tx = tx_data; end
        if (hit === 1'b1) hit_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n strobed pixels; first nov overlap; optionally overlap / restart on the last one.
    // Unstrobed cycles afterwards carry overlap and end-of-frame that must be ignored.
    task automatic frame(input int n, input int nov, input bit eof_ovl, input bit rs_eof);
        for (int i = 0; i < n; i++) begin
            stb     = 1'b1;
            eof     = (i == n - 1);
            heart   = (i < nov) || (eof && eof_ovl);
            ball    = heart;
            restart = rs_eof && eof;
            tick();
        end
        stb = 1'b0; eof = 1'b1; heart = 1'b1; ball = 1'b1; restart = 1'b0;
        tick(); tick();
        eof = 1'b0; heart = 1'b0; ball = 1'b0;
        tick();
    endtask

    task automatic pulse_restart();
        restart = 1'b1; tick(); restart = 1'b0; tick();
    endtask

    initial begin
        int tx0, h0;
        rst = 1'b1; stb = 0; heart = 0; ball = 0; eof = 0; restart = 0; idle = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_hp", hp, 20);
        check("reset_invuln", invuln, 0);
        check("reset_dead", dead, 0);
        check("reset_txdata", tx_data, 8'h00);
        tick();
        check("reset_no_tx", tx_cnt, 0);

        // First hit: 5 overlapping pixels
        frame(10, 5, 0, 0);
        check("hit1_count", hit_cnt, 1);
        check("hit1_hp", hp, 17);
        check("hit1_invuln", invuln, 1);
        check("hit1_tx_count", tx_cnt, 1);
        check("hit1_tx_byte", last_tx, 8'h48);

        // Invulnerability covers the next 30 frames
        for (int i = 0; i < 30; i++) frame(6, 6, 0, 0);
        check("iframe_hp", hp, 17);
        check("iframe_end_invuln", invuln, 0);
        frame(6, 6, 0, 0);
        check("hit2_hp", hp, 14);
        check("hit2_count", hit_cnt, 2);
        check("hit2_tx_count", tx_cnt, 2);

        // Overlap only on the end-of-frame pixel counts; unstrobed overlap does not
        pulse_restart();
        check("restart_hp", hp, 20);
        frame(8, 0, 1, 0);
        check("eof_ovl_hp", hp, 17);
        pulse_restart();
        frame(8, 0, 0, 0);
        check("nostb_ovl_hp", hp, 20);
        check("nostb_ovl_hits", hit_cnt, 3);

        // Seven hits to death; transmitter busy across the last two
        tx0 = tx_cnt;
        for (int h = 0; h < 7; h++) begin
            if (h == 5) begin idle = 1'b0; tx0 = tx_cnt; end
            frame(4, 4, 0, 0);
            if (h < 6) for (int i = 0; i < 30; i++) frame(4, 0, 0, 0);
        end
        check("death_hp", hp, 0);
        check("death_dead", dead, 1);
        check("busy_no_tx", tx_cnt, tx0);
        idle = 1'b1;
        repeat (4) tick();
        check("busy_one_tx", tx_cnt, tx0 + 1);
        check("busy_latest_byte", last_tx, 8'h44);
        tx0 = tx_cnt;
        h0 = hit_cnt;
        for (int i = 0; i < 3; i++) frame(4, 4, 0, 0);
        check("dead_sticky_hp", hp, 0);
        check("dead_no_tx", tx_cnt, tx0);
        check("dead_no_hit", hit_cnt, h0);

        // Restart coincident with a hit-producing frame end while dead
        frame(4, 4, 0, 1);
        repeat (3) tick();
        check("rs_f_hp", hp, 20);
        check("rs_f_dead", dead, 0);
        check("rs_f_invuln", invuln, 0);
        check("rs_f_hit", hit_cnt, h0);
        check("rs_f_tx", tx_cnt, tx0);

        // Randomized traffic, checked against the model every cycle
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(999) == 0);
            stb     = ($urandom_range(9) < 7);
            heart   = $urandom_range(1);
            ball    = $urandom_range(1);
            eof     = ($urandom_range(7) == 0);
            restart = ($urandom_range(299) == 0);
            idle    = ($urandom_range(9) < 6);
            tick();
        end
        rst = 0; stb = 0; heart = 0; ball = 0; eof = 0; restart = 0; idle = 1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
